alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It is the sequential companion to the single-cycle ALU in the execute stage of the pipelined MIPS core.
- Handles MULT/MULTU/DIV/DIVU iteratively and MTHI/MTLO in a single cycle.
- Exposes busy/done so hazard logic can stall MFHI/MFLO and further mul/div issue. Supports abort on pipeline flush.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even and ≥4.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  issue request; sampled in IDLE only.
- abort  in  1  pipeline flush; cancels any in-flight operation.
- op  in  mdop_t (3)  operation select.
- input_a  in  WIDTH  rs operand.
- input_b  in  WIDTH  rt operand.
- busy  out  1  high in CALC/FIX/DONE.
- done  out  1  one-cycle pulse; hi/lo hold the new result in the same cycle.
- div_zero  out  1  sticky flag, set by DIV/DIVU with input_b==0, cleared by next accepted start.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, nRST=0): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, abort=0:
  - MTHI: hi<=input_a, stay IDLE, no done.
  - MTLO: lo<=input_a, stay IDLE, no done.
  - MULT/MULTU/DIV/DIVU: latch op and the magnitudes of the operands (signed ops take two's-complement absolute value; unsigned ops use the raw value). Latch result signs, clear div_zero, counter<=0.
    - DIV/DIVU with input_b==0: go to FIX.
    - Otherwise: go to CALC.
- CALC:
  - One radix-2 step per cycle, counter++. Exit to FIX when counter==WIDTH-1, i.e. WIDTH cycles in CALC.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring division, quotient/remainder WIDTH bits each.
- FIX: one cycle.
  - Multiply: negate the 2*WIDTH product if sa^sb (signed only).
  - Divide: quotient negated if sa^sb; remainder takes the sign of the dividend.
  - Divide by zero: lo<=all ones, hi<=input_a as latched, div_zero<=1.
  - Write hi (upper/remainder) and lo (lower/quotient) at the end of FIX. Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency from the start edge to done high:
  - Normal ops: WIDTH+2 cycles.
  - Divide by zero: 2 cycles.
- Most-negative / -1 (signed DIV): lo=most negative value, hi=0. No overflow flag; this matches MIPS.
- start while busy: ignored; no queueing.
- abort: any state goes to IDLE on the next edge. hi/lo/div_zero keep their pre-start values, except that div_zero was already cleared at accept. done is not asserted. abort together with start in IDLE: abort wins, nothing is accepted.
- abort during DONE: done drops next cycle; hi/lo are already written and stay written.
- Reset mid-operation: immediate return to the reset values.
- Unknown op encoding with start: ignored, stay IDLE.

Decomposition:
- Add to cpu_types_pkg:
  - typedef enum logic[2:0] mdop_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO}.
  - typedef enum logic[1:0] md_state_t {MD_IDLE, MD_CALC, MD_FIX, MD_DONE}.
- Sub-module md_step (combinational):
  - Inputs: acc, divisor/multiplicand, mode.
  - Output: the next acc for one iteration.
  - Shared by multiply and divide, keeping the FSM file small.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, WIDTH=32 -> done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-34.
- MULT a=-3 (0xFFFFFFFD) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=7 b=0 -> done at cycle 2; div_zero=1, lo=0xFFFFFFFF, hi=0x00000007. Next accepted MULTU clears div_zero.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Abort during CALC:
  - Stimulus: MTHI 0x1234, then MULT 6*7, abort at CALC cycle 10.
  - Response: busy=0 next cycle, no done, hi=0x1234 unchanged. A start asserted during cycles 1-9 is ignored.
- Async reset pulse mid-CALC -> hi/lo/busy/done=0 immediately without a clock edge. A fresh MULTU 2*3 then gives lo=6, hi=0.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small opcode decode helpers.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdop_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  function automatic logic md_is_div(input mdop_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result bundle between the execute stage and the mul/div unit.
// The master side issues operations, the slave side is the unit itself.
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  import alu_muldiv_pkg::*;

  logic             start;
  logic             abort;
  mdop_t            op;
  logic [WIDTH-1:0] input_a;
  logic [WIDTH-1:0] input_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, abort, op, input_a, input_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, abort, op, input_a, input_b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration over the {upper, lower} accumulator: shift-add for
// multiply, restoring shift-subtract for divide.
module alu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               div_mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] trial_s;

  // Multiply keeps the multiplier in the low half and consumes it LSB first;
  // divide shifts the dividend out of the low half into the remainder.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    trial_s  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_next = acc;
    if (div_mode) begin
      if (trial_s[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {trial_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (acc[0]) begin
        acc_next = {sum_s, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers. Operands are
// reduced to magnitudes on issue and signs are restored in the FIX cycle.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  alu_muldiv_if.slave  bus
);

  localparam int CNTW = $clog2(WIDTH) + 1;

  md_state_t          state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [CNTW-1:0]    cnt_r;
  logic               div_r;
  logic               zero_r;
  logic               sa_r;
  logic               sb_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic               op_div_s;
  logic               neg_a_s;
  logic               neg_b_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic               b_zero_s;
  logic [2*WIDTH-1:0] step_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   dz_hi_s;

  // Issue-time decode: signed ops work on two's-complement magnitudes.
  always_comb begin
    op_div_s = md_is_div(bus.op);
    neg_a_s  = md_is_signed(bus.op) & bus.input_a[WIDTH-1];
    neg_b_s  = md_is_signed(bus.op) & bus.input_b[WIDTH-1];
    mag_a_s  = neg_a_s ? -bus.input_a : bus.input_a;
    mag_b_s  = neg_b_s ? -bus.input_b : bus.input_b;
    b_zero_s = (bus.input_b == {WIDTH{1'b0}});
  end

  alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .operand  (opnd_r),
    .div_mode (div_r),
    .acc_next (step_next_s)
  );

  // Sign restoration; remainder follows the dividend. The divide-by-zero
  // path never iterates, so the low half still holds |a| and sa_r rebuilds a.
  always_comb begin
    prod_s  = (sa_r ^ sb_r) ? -acc_r : acc_r;
    quot_s  = (sa_r ^ sb_r) ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s   = sa_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
    dz_hi_s = sa_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
  end

  // Control FSM and result registers; abort overrides every state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= MD_IDLE;
      acc_r   <= {(2*WIDTH){1'b0}};
      opnd_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
      div_r   <= 1'b0;
      zero_r  <= 1'b0;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.abort) begin
        state_r <= MD_IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          MD_IDLE: begin
            if (bus.start) begin
              case (bus.op)
                MD_MTHI: hi_r <= bus.input_a;
                MD_MTLO: lo_r <= bus.input_a;
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                  acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
                  opnd_r  <= mag_b_s;
                  div_r   <= op_div_s;
                  zero_r  <= op_div_s & b_zero_s;
                  sa_r    <= neg_a_s;
                  sb_r    <= neg_b_s;
                  cnt_r   <= {CNTW{1'b0}};
                  dz_r    <= 1'b0;
                  busy_r  <= 1'b1;
                  state_r <= (op_div_s && b_zero_s) ? MD_FIX : MD_CALC;
                end
                default: ;
              endcase
            end
          end
          MD_CALC: begin
            acc_r <= step_next_s;
            cnt_r <= cnt_r + CNTW'(1);
            if (cnt_r == CNTW'(WIDTH - 1)) begin
              state_r <= MD_FIX;
            end
          end
          MD_FIX: begin
            if (zero_r) begin
              lo_r <= {WIDTH{1'b1}};
              hi_r <= dz_hi_s;
              dz_r <= 1'b1;
            end else if (div_r) begin
              lo_r <= quot_s;
              hi_r <= rem_s;
            end else begin
              {hi_r, lo_r} <= prod_s;
            end
            done_r  <= 1'b1;
            state_r <= MD_DONE;
          end
          MD_DONE: begin
            busy_r  <= 1'b0;
            state_r <= MD_IDLE;
          end
          default: begin
            busy_r  <= 1'b0;
            state_r <= MD_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_fail;

  alu_muldiv_if #(.WIDTH(32)) bus ();

  alu_muldiv #(.WIDTH(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: 64-bit arithmetic; SV division truncates toward zero and the
  // remainder takes the dividend's sign, which is the MIPS behaviour.
  function automatic void model(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output logic mdz);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    mdz = 1'b0;
    mh = 32'd0;
    ml = 32'd0;
    case (op)
      MD_MULT:  begin sp = sa * sb; mh = sp[63:32]; ml = sp[31:0]; end
      MD_MULTU: begin up = ua * ub; mh = up[63:32]; ml = up[31:0]; end
      MD_DIV, MD_DIVU: begin
        if (b == 32'd0) begin
          mh = a; ml = 32'hFFFF_FFFF; mdz = 1'b1;
        end else if (op == MD_DIV) begin
          sp = sa / sb; ml = sp[31:0];
          sp = sa % sb; mh = sp[31:0];
        end else begin
          up = ua / ub; ml = up[31:0];
          up = ua % ub; mh = up[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge CLK);
    while (bus.busy === 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
  endtask

  // Issues one operation and reports the latency to done (-1 on timeout).
  task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] ohi, output logic [31:0] olo,
                        output logic odz, output logic busy_ok);
    wait_idle();
    bus.start = 1'b1; bus.op = op; bus.input_a = a; bus.input_b = b;
    busy_ok = 1'b1;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge CLK);
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    ohi = bus.hi; olo = bus.lo; odz = bus.div_zero;
  endtask

  task automatic do_move(input mdop_t op, input logic [31:0] v);
    wait_idle();
    bus.start = 1'b1; bus.op = op; bus.input_a = v; bus.input_b = 32'd0;
    @(negedge CLK);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
    n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got=%b exp=0", bus.div_zero); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_directed();
    int lat; logic [31:0] h, l; logic dz, bok;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l, dz, bok);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_lat got=%0d exp=34", lat); end
    n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL multu_busy got=%b exp=1", bok); end
    n_checks++; if (h !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got=%h exp=fffffffe", h); end
    n_checks++; if (l !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got=%h exp=00000001", l); end
    @(negedge CLK);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy35 got=%b exp=0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multu_done35 got=%b exp=0", bus.done); end

    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, lat, h, l, dz, bok);
    n_checks++; if ({h, l} !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mult_neg got=%h%h exp=fffffffffffffff1", h, l); end

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, lat, h, l, dz, bok);
    n_checks++; if (l !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got=%h exp=fffffffd", l); end
    n_checks++; if (h !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got=%h exp=ffffffff", h); end

    run_op(MD_DIVU, 32'd7, 32'd0, lat, h, l, dz, bok);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL divz_lat got=%0d exp=2", lat); end
    n_checks++; if (dz !== 1'b1) begin n_fail++; $display("FAIL divz_flag got=%b exp=1", dz); end
    n_checks++; if ({h, l} !== 64'h0000_0007_FFFF_FFFF) begin n_fail++; $display("FAIL divz_res got=%h%h exp=00000007ffffffff", h, l); end
    @(negedge CLK);
    n_checks++; if (bus.div_zero !== 1'b1) begin n_fail++; $display("FAIL divz_sticky got=%b exp=1", bus.div_zero); end

    run_op(MD_MULTU, 32'd10, 32'd10, lat, h, l, dz, bok);
    n_checks++; if (dz !== 1'b0) begin n_fail++; $display("FAIL divz_clear got=%b exp=0", dz); end

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, dz, bok);
    n_checks++; if ({h, l, dz} !== {64'h0000_0000_8000_0000, 1'b0}) begin n_fail++; $display("FAIL div_ovf got=%h%h dz=%b exp=0000000080000000 dz=0", h, l, dz); end
  endtask

  task automatic test_move();
    logic [31:0] vh, vl;
    for (int i = 0; i < 4; i++) begin
      vh = $urandom; vl = $urandom;
      do_move(MD_MTHI, vh);
      do_move(MD_MTLO, vl);
      n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL move_ctrl got done=%b busy=%b exp=0/0", bus.done, bus.busy); end
      n_checks++; if ({bus.hi, bus.lo} !== {vh, vl}) begin n_fail++; $display("FAIL move_val got=%h%h exp=%h%h", bus.hi, bus.lo, vh, vl); end
    end
  endtask

  task automatic test_random();
    int lat, elat; logic [31:0] a, b, h, l, eh, el; logic dz, edz, bok; mdop_t op;
    for (int i = 0; i < 40; i++) begin
      op = mdop_t'(3'($urandom_range(0, 3)));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 100)); b = 32'($urandom_range(1, 9)); end
        3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      model(op, a, b, eh, el, edz);
      elat = (md_is_div(op) && b == 32'd0) ? 2 : 34;
      run_op(op, a, b, lat, h, l, dz, bok);
      n_checks++;
      if (lat !== elat || bok !== 1'b1 || h !== eh || l !== el || dz !== edz) begin
        n_fail++;
        $display("FAIL rand op=%0d a=%h b=%h got lat=%0d busy=%b hi=%h lo=%h dz=%b exp lat=%0d busy=1 hi=%h lo=%h dz=%b",
                 op, a, b, lat, bok, h, l, dz, elat, eh, el, edz);
      end
    end
  endtask

  task automatic test_unknown_op();
    logic [31:0] h0, l0;
    h0 = bus.hi; l0 = bus.lo;
    wait_idle();
    bus.start = 1'b1; bus.op = mdop_t'(3'd6); bus.input_a = 32'h1111_1111; bus.input_b = 32'd3;
    @(negedge CLK);
    bus.op = mdop_t'(3'd7);
    @(negedge CLK);
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL unk_ctrl got busy=%b done=%b exp=0/0", bus.busy, bus.done); end
    n_checks++; if ({bus.hi, bus.lo} !== {h0, l0}) begin n_fail++; $display("FAIL unk_regs got=%h%h exp=%h%h", bus.hi, bus.lo, h0, l0); end
  endtask

  task automatic test_abort();
    int lat, seen; logic [31:0] h, l, eh, el; logic dz, bok, edz, busy_bad;
    run_op(MD_DIVU, 32'd9, 32'd0, lat, h, l, dz, bok);
    do_move(MD_MTHI, 32'h0000_1234);
    do_move(MD_MTLO, 32'h0000_5678);
    wait_idle();
    bus.start = 1'b1; bus.op = MD_MULT; bus.input_a = 32'd6; bus.input_b = 32'd7;
    busy_bad = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL abort_dzclr got=%b exp=0", bus.div_zero); end
      end
      if (bus.busy !== 1'b1) busy_bad = 1'b1;
      if (n < 10) begin
        bus.start = 1'b1; bus.op = MD_MTHI; bus.input_a = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0; bus.abort = 1'b1;
      end
    end
    n_checks++; if (busy_bad !== 1'b0) begin n_fail++; $display("FAIL abort_busycalc got=%b exp=0", busy_bad); end
    @(negedge CLK);
    bus.abort = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (bus.done === 1'b1) seen++;
      @(negedge CLK);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_nodone got=%0d exp=0", seen); end
    n_checks++; if ({bus.hi, bus.lo} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL abort_regs got=%h%h exp=0000123400005678", bus.hi, bus.lo); end

    // abort together with start in IDLE: nothing accepted
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = MD_MTHI; bus.input_a = 32'hBEEF_0000;
    @(negedge CLK);
    bus.op = MD_MULTU;
    @(negedge CLK);
    bus.start = 1'b0; bus.abort = 1'b0;
    n_checks++; if (bus.hi !== 32'h0000_1234 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got hi=%h busy=%b exp hi=00001234 busy=0", bus.hi, bus.busy); end

    // abort in DONE: result already written, done drops
    model(MD_MULTU, 32'h0001_0000, 32'h0003_0001, eh, el, edz);
    run_op(MD_MULTU, 32'h0001_0000, 32'h0003_0001, lat, h, l, dz, bok);
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    n_checks++; if (lat !== 34 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_done got lat=%0d done=%b busy=%b exp 34/0/0", lat, bus.done, bus.busy); end
    n_checks++; if ({bus.hi, bus.lo} !== {eh, el}) begin n_fail++; $display("FAIL abort_done_regs got=%h%h exp=%h%h", bus.hi, bus.lo, eh, el); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] h, l; logic dz, bok;
    run_op(MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, lat, h, l, dz, bok);
    wait_idle();
    bus.start = 1'b1; bus.op = MD_MULTU; bus.input_a = 32'hFFFF; bus.input_b = 32'hFFFF;
    repeat (5) begin
      @(negedge CLK);
      bus.start = 1'b0;
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got=%b exp=1", bus.busy); end
    #1 nRST = 1'b0;
    #1;
    n_checks++; if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin n_fail++; $display("FAIL arst_clear got hi=%h lo=%h busy=%b done=%b exp all 0", bus.hi, bus.lo, bus.busy, bus.done); end
    @(negedge CLK);
    nRST = 1'b1;
    run_op(MD_MULTU, 32'd2, 32'd3, lat, h, l, dz, bok);
    n_checks++; if (lat !== 34 || h !== 32'd0 || l !== 32'd6) begin n_fail++; $display("FAIL arst_after got lat=%0d hi=%h lo=%h exp 34/00000000/00000006", lat, h, l); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    nRST = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.op = MD_MULT;
    bus.input_a = 32'd0; bus.input_b = 32'd0;
    test_reset();
    test_directed();
    test_move();
    test_random();
    test_unknown_op();
    test_abort();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
